isr_controller: RTL and testbench

- Clocked, parametrised in-service register and acknowledge sequencer for the PIC.
- Sits between the priority resolver, the control logic that decodes INTA pulses, and the OCW2 write path.
- Latches the granted interrupt on the first INTA and drives the vector byte after the second INTA.
- Clears in-service bits on AEOI, non-specific EOI or specific EOI, and tracks the rotating lowest-priority level.

---
 rtl/isr_controller.sv | 209 ++++++++++++++++++++
 tb/tb_isr_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/isr_controller.sv
// In-service register and INTA acknowledge sequencer for the PIC.
// Optional ISR_SPECIAL_MASK_EN adds smm_active/imr so non-specific EOI skips masked levels.
module isr_controller #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ),
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ack_first,
    input  logic               ack_second,
    input  logic               grant_valid,
    input  logic [IDX_W-1:0]   grant_index,
    input  logic [VEC_W-1:0]   icw2_base,
    input  logic               aeoi_mode,
    input  logic               ocw2_write,
    input  logic [2:0]         ocw2_cmd,
    input  logic [IDX_W-1:0]   ocw2_level,
`ifdef ISR_SPECIAL_MASK_EN
    input  logic               smm_active,
    input  logic [NUM_IRQ-1:0] imr,
`endif
    output logic [NUM_IRQ-1:0] isr_value,
    output logic [IDX_W-1:0]   lowest_prio,
    output logic               vector_valid,
    output logic [VEC_W-1:0]   vector_data,
    output logic               eoi_pulse,
    output logic [IDX_W-1:0]   reset_index,
    output logic               spurious,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        WAIT_ACK2
    } state_t;

    localparam logic [VEC_W-1:0] BASE_MASK = {VEC_W{1'b1}} << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_IRQ - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 spur_flag_q, spur_flag_d;
    logic                 rotate_aeoi_q, rotate_aeoi_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [IDX_W-1:0]     lowest_q, lowest_d;
    logic                 vector_valid_q, vector_valid_d;
    logic [VEC_W-1:0]     vector_data_q, vector_data_d;
    logic                 eoi_pulse_q, eoi_pulse_d;
    logic [IDX_W-1:0]     reset_index_q, reset_index_d;
    logic                 spurious_q, spurious_d;

    logic [NUM_IRQ-1:0]   eoi_eligible;
    logic [NUM_IRQ-1:0]   clr_mask;
    logic [NUM_IRQ-1:0]   set_mask;
    logic                 high_found;
    logic [IDX_W-1:0]     high_idx;
    logic [IDX_W-1:0]     scan_lvl;
    logic                 aeoi_hit;
    logic                 ocw_hit;
    logic [IDX_W-1:0]     ocw_idx;

    always_comb begin
`ifdef ISR_SPECIAL_MASK_EN
        eoi_eligible = smm_active ? (isr_q & ~imr) : isr_q;
`else
        eoi_eligible = isr_q;
`endif
    end

    // Circular scan starting just above the lowest-priority level; first hit is highest priority.
    always_comb begin
        high_found = 1'b0;
        high_idx   = '0;
        scan_lvl   = '0;
        for (int i = 1; i <= NUM_IRQ; i++) begin
            scan_lvl = IDX_W'(lowest_q + IDX_W'(i));
            if (!high_found && eoi_eligible[scan_lvl]) begin
                high_found = 1'b1;
                high_idx   = scan_lvl;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        spur_flag_d    = spur_flag_q;
        rotate_aeoi_d  = rotate_aeoi_q;
        lowest_d       = lowest_q;
        vector_valid_d = 1'b0;
        vector_data_d  = vector_data_q;
        eoi_pulse_d    = 1'b0;
        reset_index_d  = reset_index_q;
        spurious_d     = 1'b0;
        clr_mask       = '0;
        set_mask       = '0;
        aeoi_hit       = 1'b0;
        ocw_hit        = 1'b0;
        ocw_idx        = '0;

        case (state_q)
            IDLE: begin
                if (ack_first) begin
                    state_d = WAIT_ACK2;
                    if (grant_valid) begin
                        idx_d                 = grant_index;
                        spur_flag_d           = 1'b0;
                        set_mask[grant_index] = 1'b1;
                    end else begin
                        idx_d       = LAST_IDX;
                        spur_flag_d = 1'b1;
                    end
                end
            end
            WAIT_ACK2: begin
                if (ack_second) begin
                    state_d        = IDLE;
                    vector_valid_d = 1'b1;
                    vector_data_d  = (icw2_base & BASE_MASK) | VEC_W'(idx_q);
                    spurious_d     = spur_flag_q;
                    if (aeoi_mode && !spur_flag_q && isr_q[idx_q]) begin
                        aeoi_hit        = 1'b1;
                        clr_mask[idx_q] = 1'b1;
                        if (rotate_aeoi_q) begin
                            lowest_d = idx_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // cmd[2] is the rotate bit for both EOI flavours.
        if (ocw2_write) begin
            case (ocw2_cmd)
                3'b001, 3'b101: begin
                    if (high_found) begin
                        ocw_hit            = 1'b1;
                        ocw_idx            = high_idx;
                        clr_mask[high_idx] = 1'b1;
                        if (ocw2_cmd[2]) begin
                            lowest_d = high_idx;
                        end
                    end
                end
                3'b011, 3'b111: begin
                    if (isr_q[ocw2_level]) begin
                        ocw_hit              = 1'b1;
                        ocw_idx              = ocw2_level;
                        clr_mask[ocw2_level] = 1'b1;
                    end
                    if (ocw2_cmd[2]) begin
                        lowest_d = ocw2_level;
                    end
                end
                3'b110:  lowest_d      = ocw2_level;
                3'b100:  rotate_aeoi_d = 1'b1;
                3'b000:  rotate_aeoi_d = 1'b0;
                default: ;
            endcase
        end

        if (aeoi_hit || ocw_hit) begin
            eoi_pulse_d   = 1'b1;
            reset_index_d = aeoi_hit ? idx_q : ocw_idx;
        end

        isr_d = (isr_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            spur_flag_q    <= 1'b0;
            rotate_aeoi_q  <= 1'b0;
            isr_q          <= '0;
            lowest_q       <= LAST_IDX;
            vector_valid_q <= 1'b0;
            vector_data_q  <= '0;
            eoi_pulse_q    <= 1'b0;
            reset_index_q  <= '0;
            spurious_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            spur_flag_q    <= spur_flag_d;
            rotate_aeoi_q  <= rotate_aeoi_d;
            isr_q          <= isr_d;
            lowest_q       <= lowest_d;
            vector_valid_q <= vector_valid_d;
            vector_data_q  <= vector_data_d;
            eoi_pulse_q    <= eoi_pulse_d;
            reset_index_q  <= reset_index_d;
            spurious_q     <= spurious_d;
        end
    end

    assign isr_value    = isr_q;
    assign lowest_prio  = lowest_q;
    assign vector_valid = vector_valid_q;
    assign vector_data  = vector_data_q;
    assign eoi_pulse    = eoi_pulse_q;
    assign reset_index  = reset_index_q;
    assign spurious     = spurious_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_isr_controller.sv
// Directed bench for isr_controller: per-cycle vector table on an 8-level instance,
// hand-written corner sequences, and a 16-level instance for wide vectors.
module tb_isr_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       ack_first, ack_second, grant_valid, aeoi_mode, ocw2_write;
    logic [2:0] grant_index, ocw2_cmd, ocw2_level;
    logic [7:0] icw2_base;
    logic [7:0] isr_value;
    logic [2:0] lowest_prio, reset_index;
    logic       vector_valid, eoi_pulse, spurious, busy;
    logic [7:0] vector_data;

    logic        af16, as16, gv16;
    logic [3:0]  gi16;
    logic [15:0] isr16;
    logic [3:0]  lowest16, ridx16;
    logic        vv16, eoi16, spur16, busy16;
    logic [7:0]  vd16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    isr_controller #(.NUM_IRQ(8)) dut8 (
        .clk(clk), .reset(reset), .ack_first(ack_first), .ack_second(ack_second),
        .grant_valid(grant_valid), .grant_index(grant_index), .icw2_base(icw2_base),
        .aeoi_mode(aeoi_mode), .ocw2_write(ocw2_write), .ocw2_cmd(ocw2_cmd),
        .ocw2_level(ocw2_level), .isr_value(isr_value), .lowest_prio(lowest_prio),
        .vector_valid(vector_valid), .vector_data(vector_data), .eoi_pulse(eoi_pulse),
        .reset_index(reset_index), .spurious(spurious), .busy(busy)
    );

    isr_controller #(.NUM_IRQ(16)) dut16 (
        .clk(clk), .reset(reset), .ack_first(af16), .ack_second(as16),
        .grant_valid(gv16), .grant_index(gi16), .icw2_base(8'hA0),
        .aeoi_mode(1'b0), .ocw2_write(1'b0), .ocw2_cmd(3'b000),
        .ocw2_level(4'h0), .isr_value(isr16), .lowest_prio(lowest16),
        .vector_valid(vv16), .vector_data(vd16), .eoi_pulse(eoi16),
        .reset_index(ridx16), .spurious(spur16), .busy(busy16)
    );

    typedef struct {
        int rst, af, as, gv, gi, aeoi, ow, cmd, lvl;
        int isr, lp, vv, vd, eoi, ri, sp, bz;
    } vec_t;

    vec_t tbl[31];

    // Drive one cycle of inputs on the falling edge, then let the rising edge register them.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset       = v.rst[0];
        ack_first   = v.af[0];
        ack_second  = v.as[0];
        grant_valid = v.gv[0];
        grant_index = 3'(v.gi);
        aeoi_mode   = v.aeoi[0];
        ocw2_write  = v.ow[0];
        ocw2_cmd    = 3'(v.cmd);
        ocw2_level  = 3'(v.lvl);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int rst, input int af, input int as, input int gv, input int gi,
                        input int aeoi, input int ow, input int cmd, input int lvl);
        vec_t v;
        v = '{rst, af, as, gv, gi, aeoi, ow, cmd, lvl, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(v);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    task automatic checkRow(input int r, input vec_t v);
        checkOutput($sformatf("row%0d isr_value", r),    int'(isr_value),    v.isr);
        checkOutput($sformatf("row%0d lowest_prio", r),  int'(lowest_prio),  v.lp);
        checkOutput($sformatf("row%0d vector_valid", r), int'(vector_valid), v.vv);
        checkOutput($sformatf("row%0d vector_data", r),  int'(vector_data),  v.vd);
        checkOutput($sformatf("row%0d eoi_pulse", r),    int'(eoi_pulse),    v.eoi);
        checkOutput($sformatf("row%0d reset_index", r),  int'(reset_index),  v.ri);
        checkOutput($sformatf("row%0d spurious", r),     int'(spurious),     v.sp);
        checkOutput($sformatf("row%0d busy", r),         int'(busy),         v.bz);
    endtask

    initial begin
        icw2_base = 8'h40;
        af16 = 1'b0; as16 = 1'b0; gv16 = 1'b0; gi16 = 4'h0;

        //            rst af as gv gi ae ow cmd lvl  isr    lp vv vd     eoi ri sp bz
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 7, 0, 'h00, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 5, 0, 0, 0, 0, 'h20, 7, 0, 'h00, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h20, 7, 1, 'h45, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h20, 7, 0, 'h45, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 1, 3, 5, 'h00, 7, 0, 'h45, 1, 5, 0, 0};
        tbl[5]  = '{0, 1, 0, 1, 3, 1, 0, 0, 0, 'h08, 7, 0, 'h45, 0, 5, 0, 1};
        tbl[6]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 'h00, 7, 1, 'h43, 1, 3, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 7, 0, 'h43, 0, 3, 0, 0};
        tbl[8]  = '{0, 1, 0, 1, 2, 0, 0, 0, 0, 'h04, 7, 0, 'h43, 0, 3, 0, 1};
        tbl[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h04, 7, 1, 'h42, 0, 3, 0, 0};
        tbl[10] = '{0, 1, 0, 1, 5, 0, 0, 0, 0, 'h24, 7, 0, 'h42, 0, 3, 0, 1};
        tbl[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h24, 7, 1, 'h45, 0, 3, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 'h20, 7, 0, 'h45, 1, 2, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 5, 0, 'h00, 5, 0, 'h45, 1, 5, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 1, 6, 0, 'h00, 0, 0, 'h45, 0, 5, 0, 0};
        tbl[15] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 'h01, 0, 0, 'h45, 0, 5, 0, 1};
        tbl[16] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h01, 0, 1, 'h40, 0, 5, 0, 0};
        tbl[17] = '{0, 1, 0, 1, 7, 0, 0, 0, 0, 'h81, 0, 0, 'h40, 0, 5, 0, 1};
        tbl[18] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h81, 0, 1, 'h47, 0, 5, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 'h01, 0, 0, 'h47, 1, 7, 0, 0};
        tbl[20] = '{0, 0, 0, 0, 0, 0, 1, 3, 4, 'h01, 0, 0, 'h47, 0, 7, 0, 0};
        tbl[21] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 'h00, 0, 0, 'h47, 1, 0, 0, 0};
        tbl[22] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 'h00, 0, 0, 'h47, 0, 0, 0, 0};
        tbl[23] = '{0, 1, 0, 0, 3, 0, 0, 0, 0, 'h00, 0, 0, 'h47, 0, 0, 0, 1};
        tbl[24] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h00, 0, 1, 'h47, 0, 0, 1, 0};
        tbl[25] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h00, 0, 0, 'h47, 0, 0, 0, 0};
        tbl[26] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 'h00, 0, 0, 'h47, 0, 0, 0, 1};
        tbl[27] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 'h00, 0, 1, 'h47, 0, 0, 1, 0};
        tbl[28] = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 'h02, 0, 0, 'h47, 0, 0, 0, 1};
        tbl[29] = '{0, 1, 0, 1, 6, 0, 0, 0, 0, 'h02, 0, 0, 'h47, 0, 0, 0, 1};
        tbl[30] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 'h02, 0, 1, 'h41, 0, 0, 0, 0};

        for (int r = 0; r < 31; r++) begin
            applyStimulus(tbl[r]);
            checkRow(r, tbl[r]);
        end

        // ack_first set wins over a same-cycle specific EOI on the same level
        step(0, 1, 0, 1, 1, 0, 1, 3, 1);
        checkOutput("set wins isr_value", int'(isr_value), 'h02);
        checkOutput("set wins busy", int'(busy), 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("set wins vector_data", int'(vector_data), 'h41);
        step(0, 0, 0, 0, 0, 0, 1, 3, 1);
        checkOutput("cleanup isr_value", int'(isr_value), 'h00);

        // AEOI and specific EOI in the same cycle: both clear, AEOI level reported
        step(0, 1, 0, 1, 4, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 6, 1, 0, 0, 0);
        checkOutput("dual pre isr_value", int'(isr_value), 'h50);
        step(0, 0, 1, 0, 0, 1, 1, 3, 4);
        checkOutput("dual isr_value", int'(isr_value), 'h00);
        checkOutput("dual eoi_pulse", int'(eoi_pulse), 1);
        checkOutput("dual reset_index", int'(reset_index), 6);
        checkOutput("dual vector_data", int'(vector_data), 'h46);

        // Rotate-on-AEOI moves lowest priority; clearing the mode stops it
        step(0, 0, 0, 0, 0, 0, 1, 4, 0);
        step(0, 1, 0, 1, 2, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("rot aeoi lowest_prio", int'(lowest_prio), 2);
        checkOutput("rot aeoi reset_index", int'(reset_index), 2);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 3, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0, 0);
        checkOutput("no rot lowest_prio", int'(lowest_prio), 2);
        checkOutput("no rot reset_index", int'(reset_index), 3);

        // Rotate on specific EOI with an empty ISR still rotates, with no pulse
        step(0, 0, 0, 0, 0, 0, 1, 7, 3);
        checkOutput("rse empty lowest_prio", int'(lowest_prio), 3);
        checkOutput("rse empty eoi_pulse", int'(eoi_pulse), 0);

        // Reset between the two INTA pulses discards the pending vector
        step(0, 1, 0, 1, 3, 0, 0, 0, 0);
        checkOutput("mid reset pre isr_value", int'(isr_value), 'h08);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid reset isr_value", int'(isr_value), 'h00);
        checkOutput("mid reset busy", int'(busy), 0);
        checkOutput("mid reset lowest_prio", int'(lowest_prio), 7);
        checkOutput("mid reset vector_data", int'(vector_data), 'h00);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("mid reset vector_valid", int'(vector_valid), 0);
        checkOutput("mid reset busy after", int'(busy), 0);

        // 16-level instance: grant 12 on base A0
        checkOutput("w16 reset lowest_prio", int'(lowest16), 15);
        @(negedge clk);
        af16 = 1'b1; gv16 = 1'b1; gi16 = 4'hC;
        @(posedge clk); #1;
        checkOutput("w16 isr_value", int'(isr16), 'h1000);
        checkOutput("w16 busy", int'(busy16), 1);
        @(negedge clk);
        af16 = 1'b0; gv16 = 1'b0; gi16 = 4'h0; as16 = 1'b1;
        @(posedge clk); #1;
        checkOutput("w16 vector_valid", int'(vv16), 1);
        checkOutput("w16 vector_data", int'(vd16), 'hAC);
        checkOutput("w16 spurious", int'(spur16), 0);
        @(negedge clk);
        as16 = 1'b0;
        @(posedge clk); #1;
        checkOutput("w16 vector_valid drop", int'(vv16), 0);
        checkOutput("w16 vector_data hold", int'(vd16), 'hAC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
